// File: rtl/pll_lock_ctrl_pkg.sv
// Shared types and constants for the PLL reset/lock sequencer.
// Build option PLL_LOCK_CTRL_STATS_EN is consumed by pll_lock_ctrl.sv.
package pll_lock_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam int RETRY_W = 8;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 125000;
  localparam int DEF_STABLE_CYCLES = 1250;
  localparam int DEF_MAX_RETRIES   = 7;
  localparam int DEF_CNT_W         = 16;

  // Bits needed for a counter that runs 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_lock_ctrl_if.sv
// Signal bundle between the lock sequencer (master) and the PLL/downstream side (slave).
// Signal semantics: there is no valid/ready pairing here. pll_locked is a level,
// asynchronous to refclk, synchronised inside the controller. relock_req is a
// single-cycle request pulse with no acknowledge; it is honoured in WAIT_LOCK,
// SETTLE, RUN and FAIL and dropped in RESET. All controller outputs, including
// the debug copy of the state, change only on refclk rising edges.
interface pll_lock_ctrl_if #(
  parameter int CNT_W = 16
);
  import pll_lock_ctrl_pkg::*;

  logic                 pll_rst;
  logic                 pll_locked;
  logic                 relock_req;
  logic                 sys_rst_n;
  logic                 lock_ok;
  logic                 fail;
  logic [RETRY_W-1:0]   retry_cnt;
  logic [CNT_W-1:0]     loss_cnt;
  state_t               state;

  modport master (
    output pll_rst, sys_rst_n, lock_ok, fail, retry_cnt, loss_cnt, state,
    input  pll_locked, relock_req
  );

  modport slave (
    input  pll_rst, sys_rst_n, lock_ok, fail, retry_cnt, loss_cnt, state,
    output pll_locked, relock_req
  );

endinterface

// File: rtl/pll_lock_ctrl_bit_sync.sv
// Two-flop synchroniser, synchronous active-low reset to zero.
module bit_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two register stages to resolve metastability of the asynchronous input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for a debounced lock with a
// timeout, then releases the downstream reset; restarts on lock loss or request.
// Build option PLL_LOCK_CTRL_STATS_EN: when defined, retry_cnt and loss_cnt are
// real counters; when undefined they read zero and only a small internal retry
// counter remains for the FAIL decision.
module pll_lock_ctrl
  import pll_lock_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic           refclk,
  input  logic           rst_n,
  pll_lock_ctrl_if.master bus
);

  localparam int RT_W = cnt_width(RST_CYCLES);
  localparam int TO_W = cnt_width(LOCK_TIMEOUT);
  localparam int ST_W = cnt_width(STABLE_CYCLES);
`ifdef PLL_LOCK_CTRL_STATS_EN
  localparam int RC_W = RETRY_W;
`else
  localparam int RC_W = cnt_width(MAX_RETRIES + 1);
`endif

  localparam logic [RT_W-1:0] RST_LAST    = RT_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [ST_W-1:0] ST_LAST     = ST_W'(STABLE_CYCLES - 1);
  localparam logic [RC_W-1:0] RETRY_LIMIT = RC_W'(MAX_RETRIES);

  state_t          state, next_state;
  logic            lk_s;
  logic [RT_W-1:0] rst_tmr;
  logic [TO_W-1:0] to_tmr;
  logic [ST_W-1:0] st_tmr;
  logic [RC_W-1:0] retry_q;
  logic [RC_W-1:0] retry_inc;
  logic            timeout;
  logic            retry_limit;
  logic            retry_event;
  logic            retry_clear;
  logic            pll_rst_d, sys_rst_n_d, lock_ok_d, fail_d;
  logic            pll_rst_q, sys_rst_n_q, lock_ok_q, fail_q;

  bit_sync #(.W(1)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (bus.pll_locked),
    .q     (lk_s)
  );

  // The timeout timer spans WAIT_LOCK and SETTLE so chattering lock still expires.
  assign timeout     = (to_tmr == TO_LAST);
  assign retry_inc   = (retry_q == '1) ? retry_q : retry_q + 1'b1;
  assign retry_limit = (MAX_RETRIES != 0) && (retry_inc == RETRY_LIMIT);

  // State register.
  always_ff @(posedge refclk) begin
    if (!rst_n) state <= RESET;
    else        state <= next_state;
  end

  // Next-state decode; relock_req outranks timeout, timeout outranks lock status.
  always_comb begin
    next_state = state;
    case (state)
      RESET: begin
        if (rst_tmr == RST_LAST) next_state = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (bus.relock_req)  next_state = RESET;
        else if (timeout)    next_state = retry_limit ? FAIL : RESET;
        else if (lk_s)       next_state = SETTLE;
      end
      SETTLE: begin
        if (bus.relock_req)       next_state = RESET;
        else if (timeout)         next_state = retry_limit ? FAIL : RESET;
        else if (!lk_s)           next_state = WAIT_LOCK;
        else if (st_tmr == ST_LAST) next_state = RUN;
      end
      RUN: begin
        if (!lk_s || bus.relock_req) next_state = RESET;
      end
      FAIL: begin
        if (bus.relock_req) next_state = RESET;
      end
      default: next_state = RESET;
    endcase
  end

  // Output decode from the next state so outputs register alongside the state.
  always_comb begin
    pll_rst_d   = 1'b0;
    sys_rst_n_d = 1'b0;
    lock_ok_d   = 1'b0;
    fail_d      = 1'b0;
    case (next_state)
      RESET: pll_rst_d = 1'b1;
      RUN: begin
        sys_rst_n_d = 1'b1;
        lock_ok_d   = 1'b1;
      end
      FAIL: begin
        pll_rst_d = 1'b1;
        fail_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      lock_ok_q   <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      lock_ok_q   <= lock_ok_d;
      fail_q      <= fail_d;
    end
  end

  // Timers run only while the relevant state persists and restart on entry.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      rst_tmr <= '0;
      to_tmr  <= '0;
      st_tmr  <= '0;
    end else begin
      rst_tmr <= (state == RESET && next_state == RESET) ? rst_tmr + 1'b1 : '0;
      st_tmr  <= (state == SETTLE && next_state == SETTLE) ? st_tmr + 1'b1 : '0;
      to_tmr  <= ((state == WAIT_LOCK || state == SETTLE) &&
                  (next_state == WAIT_LOCK || next_state == SETTLE)) ? to_tmr + 1'b1 : '0;
    end
  end

  assign retry_event = (state == WAIT_LOCK || state == SETTLE) && !bus.relock_req && timeout;
  assign retry_clear = (state == SETTLE && next_state == RUN) ||
                       (state == FAIL && next_state == RESET);

  // Consecutive-timeout counter; also drives the FAIL decision.
  always_ff @(posedge refclk) begin
    if (!rst_n)           retry_q <= '0;
    else if (retry_event) retry_q <= retry_inc;
    else if (retry_clear) retry_q <= '0;
  end

`ifdef PLL_LOCK_CTRL_STATS_EN
  logic [CNT_W-1:0] loss_q;

  // Lock-loss counter, saturating; a simultaneous relock_req still counts as a loss.
  always_ff @(posedge refclk) begin
    if (!rst_n)                                    loss_q <= '0;
    else if (state == RUN && !lk_s && loss_q != '1) loss_q <= loss_q + 1'b1;
  end

  assign bus.retry_cnt = retry_q;
  assign bus.loss_cnt  = loss_q;
`else
  assign bus.retry_cnt = {RETRY_W{1'b0}};
  assign bus.loss_cnt  = {CNT_W{1'b0}};
`endif

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst_n = sys_rst_n_q;
  assign bus.lock_ok   = lock_ok_q;
  assign bus.fail      = fail_q;
  assign bus.state     = state;

endmodule
